// File: rtl/fpu_share_arb_pkg.sv
// Shared types and helpers for the FP-unit sharing arbiter.
// Optional feature macro: FPU_SHARE_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
package fpu_share_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    RETURN = 2'd2
  } fpu_arb_state_t;

  localparam int NREQ_DEFAULT = 4;

  // Pointer starts on the highest index so requester 0 is searched first after reset.
  localparam int RR_LAST_RESET_DEFAULT = NREQ_DEFAULT - 1;

  function automatic int rr_last_reset(input int nreq);
    return nreq - 1;
  endfunction

endpackage

// File: rtl/fpu_share_arbiter_rr_pick.sv
// Combinational requester picker: round-robin after `last`, or fixed priority
// (lowest index) when FPU_SHARE_ARB_FIXED_PRIO_EN is defined.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [IDW-1:0]  winner,
  output logic            any
);

  assign any = |req;

`ifdef FPU_SHARE_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) winner = IDW'(i);
    end
  end
`else
  // Walk the search order backwards so the earliest hit after `last` wins.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (req[idx]) winner = IDW'(idx);
    end
  end
`endif

endmodule

// File: rtl/fpu_share_arbiter.sv
// Shares one multi-cycle FP unit among NREQ requesters: pick, issue one u_en, wait for u_done, return.
// Optional feature macro: FPU_SHARE_ARB_FIXED_PRIO_EN (fixed priority, no round-robin pointer).
module fpu_share_arbiter
  import fpu_share_arb_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 32,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_adata,
  input  logic [NREQ*WIDTH-1:0] req_bdata,
  output logic [WIDTH-1:0]      resp_result,
  output logic [NREQ-1:0]       resp_done,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy,
  output logic                  u_en,
  output logic [WIDTH-1:0]      u_adata,
  output logic [WIDTH-1:0]      u_bdata,
  input  logic [WIDTH-1:0]      u_result,
  input  logic                  u_done,
  input  logic                  u_busy
);

  logic [WIDTH-1:0] a_slice [NREQ];
  logic [WIDTH-1:0] b_slice [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign a_slice[gi] = req_adata[gi*WIDTH +: WIDTH];
    assign b_slice[gi] = req_bdata[gi*WIDTH +: WIDTH];
  end

  fpu_arb_state_t   state_q, state_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [WIDTH-1:0] adata_q, adata_d;
  logic [WIDTH-1:0] bdata_q, bdata_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             busy_q, busy_d;
  logic             u_en_q, u_en_d;

  logic [IDW-1:0]   pick_last;
  logic [IDW-1:0]   pick_win;
  logic             pick_any;
  logic             op_done;

  // The unit may not have registered its start yet, so u_done in the u_en cycle is stale.
  assign op_done = (state_q == WAIT) && u_done && !u_en_q;

`ifdef FPU_SHARE_ARB_FIXED_PRIO_EN
  assign pick_last = '0;
`else
  localparam logic [IDW-1:0] LAST_RST = IDW'(rr_last_reset(NREQ));

  logic [IDW-1:0] last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (op_done) last_d = grant_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) last_q <= LAST_RST;
    else       last_q <= last_d;
  end

  assign pick_last = last_q;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req    (req),
    .last   (pick_last),
    .winner (pick_win),
    .any    (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    adata_d  = adata_q;
    bdata_d  = bdata_q;
    result_d = result_q;
    done_d   = '0;
    busy_d   = busy_q;
    u_en_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any && !u_busy) begin
          grant_d = pick_win;
          adata_d = a_slice[pick_win];
          bdata_d = b_slice[pick_win];
          u_en_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (op_done) begin
          result_d        = u_result;
          done_d[grant_q] = 1'b1;
          state_d         = RETURN;
        end
      end
      RETURN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      adata_q  <= '0;
      bdata_q  <= '0;
      result_q <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      u_en_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      adata_q  <= adata_d;
      bdata_q  <= bdata_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      u_en_q   <= u_en_d;
    end
  end

  assign resp_result = result_q;
  assign resp_done   = done_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign u_en        = u_en_q;
  assign u_adata     = adata_q;
  assign u_bdata     = bdata_q;

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Directed scoreboard bench for fpu_share_arbiter with a 3-cycle FP multiplier model.
module tb_fpu_share_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_adata;
  logic [NREQ*WIDTH-1:0] req_bdata;
  logic [WIDTH-1:0]      resp_result;
  logic [NREQ-1:0]       resp_done;
  logic [IDW-1:0]        grant_id;
  logic                  busy;
  logic                  u_en;
  logic [WIDTH-1:0]      u_adata;
  logic [WIDTH-1:0]      u_bdata;
  logic [WIDTH-1:0]      u_result;
  logic                  u_done;
  logic                  u_busy;

  logic [WIDTH-1:0] op_a [NREQ];
  logic [WIDTH-1:0] op_b [NREQ];
  logic             busy_force;
  logic             inj_done;

  int errors = 0;
  int checks = 0;
  int en_count = 0;
  logic en_prev = 1'b0;

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] res;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ops
    assign req_adata[gi*WIDTH +: WIDTH] = op_a[gi];
    assign req_bdata[gi*WIDTH +: WIDTH] = op_b[gi];
  end

  fpu_share_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req         (req),
    .req_adata   (req_adata),
    .req_bdata   (req_bdata),
    .resp_result (resp_result),
    .resp_done   (resp_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .u_en        (u_en),
    .u_adata     (u_adata),
    .u_bdata     (u_bdata),
    .u_result    (u_result),
    .u_done      (u_done),
    .u_busy      (u_busy)
  );

  // Normal-number fp32 multiply, truncating.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [23:0] ma, mb;
    logic [47:0] p;
    logic [9:0]  e;
    logic        s;
    ma = {1'b1, a[22:0]};
    mb = {1'b1, b[22:0]};
    p  = ma * mb;
    s  = a[31] ^ b[31];
    e  = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
    if (p[47]) begin
      e = e + 10'd1;
      return {s, e[7:0], p[46:24]};
    end
    return {s, e[7:0], p[45:23]};
  endfunction

  // Unit model: u_done exactly three cycles after u_en.
  logic             m_pend;
  logic [1:0]       m_cnt;
  logic             m_done;
  logic [WIDTH-1:0] m_a, m_b;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_pend   <= 1'b0;
      m_cnt    <= 2'd0;
      m_done   <= 1'b0;
      m_a      <= '0;
      m_b      <= '0;
      u_result <= '0;
    end else begin
      m_done <= 1'b0;
      if (u_en) begin
        m_pend <= 1'b1;
        m_cnt  <= 2'd0;
        m_a    <= u_adata;
        m_b    <= u_bdata;
      end else if (m_pend) begin
        if (m_cnt == 2'd1) begin
          m_done   <= 1'b1;
          u_result <= fmul(m_a, m_b);
          m_pend   <= 1'b0;
        end
        m_cnt <= m_cnt + 2'd1;
      end
    end
  end

  assign u_done = m_done | inj_done;
  assign u_busy = m_pend | u_en | busy_force;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int i);
    sb.push_back(exp_t'{IDW'(i), fmul(op_a[i], op_b[i])});
  endtask

  // Monitor: operand forwarding on each issue, scoreboard pop on each completion.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rstn === 1'b1) begin
      if (u_en === 1'b1) begin
        en_count++;
        chk("u_en_single_cycle", 32'(en_prev), 32'd0);
        chk("issue_with_pending_sb", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          chk("grant_id", 32'(grant_id), 32'(sb[0].id));
          chk("u_adata_fwd", u_adata, op_a[sb[0].id]);
          chk("u_bdata_fwd", u_bdata, op_b[sb[0].id]);
        end
      end
      if (resp_done !== '0) begin
        chk("resp_done_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("resp_done_onehot", 32'(resp_done), 32'(1) << e.id);
          chk("resp_result", resp_result, e.res);
          chk("busy_at_done", 32'(busy), 32'd1);
          $display("txn: requester=%0d result=0x%08h", e.id, resp_result);
        end
      end
    end
    en_prev <= u_en;
  end

  task automatic wait_done(output logic [NREQ-1:0] d);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (resp_done === '0 && n < 40);
    chk("resp_done_timeout", 32'(resp_done === '0), 32'd0);
    d = resp_done;
  endtask

  task automatic wait_en();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (u_en !== 1'b1 && n < 20);
    chk("u_en_timeout", 32'(u_en), 32'd1);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin : wd
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] d;
    int base;
    int prio_seq [5];

    rstn       = 1'b0;
    req        = '0;
    busy_force = 1'b0;
    inj_done   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    repeat (2) @(negedge clk);

    chk("rst_resp_result", resp_result, 32'd0);
    chk("rst_resp_done", 32'(resp_done), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_u_en", 32'(u_en), 32'd0);
    chk("rst_u_adata", u_adata, 32'd0);
    chk("rst_u_bdata", u_bdata, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Single operation: 1.5 * 2.0 = 3.0
    op_a[0] = 32'h3FC0_0000;
    op_b[0] = 32'h4000_0000;
    push_exp(0);
    req = 4'b0001;
    @(negedge clk);
    chk("single_u_en", 32'(u_en), 32'd1);
    chk("single_u_adata", u_adata, 32'h3FC0_0000);
    chk("single_u_bdata", u_bdata, 32'h4000_0000);
    chk("single_busy", 32'(busy), 32'd1);
    wait_done(d);
    chk("single_done", 32'(d), 32'h1);
    chk("single_result", resp_result, 32'h4040_0000);
    req = req & ~d;
    @(negedge clk);
    chk("single_busy_after", 32'(busy), 32'd0);
    chk("single_result_hold", resp_result, 32'h4040_0000);

    // All four at once after a fresh reset: order 0,1,2,3
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = 32'h3F80_0000 + (32'(i + 1) << 20);
      op_b[i] = 32'h4000_0000 + (32'(i) << 21);
      push_exp(i);
    end
    req = 4'b1111;
    for (int k = 0; k < NREQ; k++) begin
      wait_done(d);
      chk("all4_order", 32'(d), 32'(1) << k);
      req = req & ~d;
    end

    // Wrap-around: serve 3 alone, then 0 must beat 3
    op_a[3] = 32'h4110_0000;
    op_b[3] = 32'h3F40_0000;
    push_exp(3);
    req = 4'b1000;
    wait_done(d);
    chk("wrap_first", 32'(d), 32'h8);
    req = req & ~d;
    op_a[0] = 32'h40A0_0000;
    op_b[0] = 32'h40C0_0000;
    op_a[3] = 32'h3E80_0000;
    op_b[3] = 32'h4200_0000;
    push_exp(0);
    push_exp(3);
    req = 4'b1001;
    wait_done(d);
    chk("wrap_zero_first", 32'(d), 32'h1);
    req = req & ~d;
    wait_done(d);
    chk("wrap_three_next", 32'(d), 32'h8);
    req = req & ~d;

    // Requester 2 drops req while its operation is in flight
    op_a[2] = 32'h4150_0000;
    op_b[2] = 32'h3FA0_0000;
    push_exp(2);
    req = 4'b0100;
    wait_en();
    req = '0;
    wait_done(d);
    chk("drop_done", 32'(d), 32'h4);
    base = en_count;
    repeat (8) @(negedge clk);
    chk("drop_no_new_en", 32'(en_count), 32'(base));
    chk("drop_busy_low", 32'(busy), 32'd0);

    // Unit busy blocks issue; stray u_done in IDLE is ignored
    busy_force = 1'b1;
    op_a[1] = 32'h3FE0_0000;
    op_b[1] = 32'h4080_0000;
    push_exp(1);
    req = 4'b0010;
    base = en_count;
    repeat (4) @(negedge clk);
    chk("ubusy_no_en", 32'(en_count), 32'(base));
    chk("ubusy_no_busy", 32'(busy), 32'd0);
    busy_force = 1'b0;
    wait_done(d);
    chk("ubusy_then_done", 32'(d), 32'h2);
    req = req & ~d;
    repeat (2) @(negedge clk);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    chk("stray_done_ignored", 32'(resp_done), 32'd0);
    @(negedge clk);
    chk("stray_done_no_pulse", 32'(resp_done), 32'd0);
    chk("stray_done_busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of an operation
    op_a[1] = 32'h4040_0000;
    op_b[1] = 32'h4040_0000;
    push_exp(1);
    req = 4'b0010;
    wait_en();
    @(posedge clk);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    sb.delete();
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_grant_id", 32'(grant_id), 32'd0);
    chk("arst_u_adata", u_adata, 32'd0);
    chk("arst_u_bdata", u_bdata, 32'd0);
    chk("arst_resp_result", resp_result, 32'd0);
    chk("arst_u_en", 32'(u_en), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    push_exp(1);
    wait_done(d);
    chk("arst_recover", 32'(d), 32'h2);
    req = req & ~d;
    @(negedge clk);

    // Requesters 0 and 1 held continuously for five operations
`ifdef FPU_SHARE_ARB_FIXED_PRIO_EN
    prio_seq = '{0, 0, 0, 0, 0};
`else
    prio_seq = '{0, 1, 0, 1, 0};
`endif
    op_a[0] = 32'h3F90_0000;
    op_b[0] = 32'h4020_0000;
    op_a[1] = 32'h40E0_0000;
    op_b[1] = 32'h3F00_0000;
    for (int k = 0; k < 5; k++) push_exp(prio_seq[k]);
    req = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      wait_done(d);
      chk("held_pair_order", 32'(d), 32'(1) << prio_seq[k]);
    end
    req = '0;
    repeat (6) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
